// File: rtl/mod_counter_prog_pkg.sv
// ---------------------------------------------------------------------------
// mod_counter_pkg
// Shared definitions for the programmable modulo counter:
//   - mode_e    : counting mode encodings driven on the 2-bit mode port
//   - clamp_val : saturates a value into an inclusive [lo, hi] window; used
//                 for both the programmed modulus and the preload value
// ---------------------------------------------------------------------------
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,  // count up, wrap M-1 -> 0
    MODE_DOWN     = 2'b01,  // count down, wrap 0 -> M-1
    MODE_ONESHOT  = 2'b10,  // count up to M-1, then stop and flag done
    MODE_PINGPONG = 2'b11   // bounce 0 .. M-1 .. 0
  } mode_e;

  // Saturate v into [lo, hi]. Callers guarantee lo <= hi.
  function automatic int unsigned clamp_val(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
    int unsigned r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/mod_next_calc.sv
// ---------------------------------------------------------------------------
// mod_next_calc
// Purely combinational next-state calculator for mod_counter_prog. Given the
// current count, modulus, mode, direction and done flag it produces what the
// counter would become on an enabled clock edge.
//
// Ports:
//   count      in  CW  current count (always < m)
//   m          in  MW  active modulus (2..MAX_MOD)
//   mode       in  2   counting mode (mode_e)
//   dir        in  1   current direction, 1 = up
//   done       in  1   one-shot finished flag
//   next_count out CW  count after an enabled edge
//   next_dir   out 1   direction after an enabled edge
//   wrap_evt   out 1   this enabled edge is a wrap / turnaround / one-shot end
//   tc_raw     out 1   count sits at its terminal value (not yet gated by en)
// ---------------------------------------------------------------------------
module mod_next_calc
  import mod_counter_pkg::*;
#(
  parameter int CW = 4,
  parameter int MW = 4
) (
  input  logic [CW-1:0] count,
  input  logic [MW-1:0] m,
  input  logic [1:0]    mode,
  input  logic          dir,
  input  logic          done,
  output logic [CW-1:0] next_count,
  output logic          next_dir,
  output logic          wrap_evt,
  output logic          tc_raw
);

  logic [MW-1:0] count_ext;
  logic [MW-1:0] m_minus1;
  logic          at_top;
  logic          at_zero;
  logic [CW-1:0] count_inc;
  logic [CW-1:0] count_dec;
  logic [CW-1:0] top_val;
  logic [CW-1:0] turn_val;

  // Comparisons against the modulus are done at MW bits so that a modulus of
  // exactly 2**CW still works.
  assign count_ext = MW'(count);
  assign m_minus1  = m - MW'(1);
  assign at_top    = (count_ext == m_minus1);
  assign at_zero   = (count == '0);

  // count < m always holds, so m-1 and m-2 fit in CW bits.
  assign count_inc = count + CW'(1);
  assign count_dec = count - CW'(1);
  assign top_val   = CW'(m_minus1);
  assign turn_val  = CW'(m - MW'(2));

  always_comb begin
    next_count = count;
    next_dir   = dir;
    wrap_evt   = 1'b0;
    tc_raw     = 1'b0;

    case (mode_e'(mode))
      MODE_UP: begin
        next_dir   = 1'b1;
        tc_raw     = at_top;
        wrap_evt   = at_top;
        next_count = at_top ? '0 : count_inc;
      end

      MODE_DOWN: begin
        next_dir   = 1'b0;
        tc_raw     = at_zero;
        wrap_evt   = at_zero;
        next_count = at_zero ? top_val : count_dec;
      end

      MODE_ONESHOT: begin
        next_dir = 1'b1;
        // Once done, the counter is frozen and no longer reports terminal.
        tc_raw   = at_top && !done;
        if (done) begin
          next_count = count;
        end else if (at_top) begin
          next_count = count;
          wrap_evt   = 1'b1;
        end else begin
          next_count = count_inc;
        end
      end

      MODE_PINGPONG: begin
        if (dir) begin
          tc_raw = at_top;
          if (at_top) begin
            // Turn around at the top; M-2 is 0 when M=2, giving 0,1,0,1.
            next_count = turn_val;
            next_dir   = 1'b0;
            wrap_evt   = 1'b1;
          end else begin
            next_count = count_inc;
          end
        end else begin
          tc_raw = at_zero;
          if (at_zero) begin
            next_count = CW'(1);
            next_dir   = 1'b1;
            wrap_evt   = 1'b1;
          end else begin
            next_count = count_dec;
          end
        end
      end

      default: begin
        next_count = count;
      end
    endcase
  end

endmodule

// File: rtl/mod_counter_prog.sv
// ---------------------------------------------------------------------------
// mod_counter_prog
// Runtime-programmable modulo counter with up, down, one-shot and ping-pong
// modes, synchronous preload and a cascade-friendly terminal count.
// Edge priority: cfg_we > load > en. tc feeds the next stage's en directly.
//
// Ports:
//   clk      in  1   rising-edge clock
//   reset    in  1   asynchronous active-low reset
//   en       in  1   count enable / cascade carry-in
//   mode     in  2   00 up, 01 down, 10 one-shot, 11 ping-pong
//   cfg_we   in  1   capture mod_in (clamped to 2..MAX_MOD) as modulus
//   mod_in   in  MW  new modulus
//   load     in  1   synchronous preload of count
//   load_val in  CW  preload value (clamped to M-1)
//   count    out CW  current count
//   tc       out 1   terminal count, combinational, gated by en
//   wrap     out 1   registered one-cycle pulse on wrap / turnaround
//   dir      out 1   current direction, 1 = up
//   done     out 1   sticky one-shot finished flag
// ---------------------------------------------------------------------------
module mod_counter_prog
  import mod_counter_pkg::*;
#(
  parameter int MAX_MOD = 10,
  parameter int CW      = $clog2(MAX_MOD),
  parameter int MW      = $clog2(MAX_MOD + 1),
  parameter int DEF_MOD = MAX_MOD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic          cfg_we,
  input  logic [MW-1:0] mod_in,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          tc,
  output logic          wrap,
  output logic          dir,
  output logic          done
);

  logic [CW-1:0] count_q;
  logic [MW-1:0] mod_q;
  logic          dir_q;
  logic          wrap_q;
  logic          done_q;

  logic [CW-1:0] next_count;
  logic          next_dir;
  logic          wrap_evt;
  logic          tc_raw;

  logic [MW-1:0] mod_new;
  logic [CW-1:0] load_lim;
  logic [CW-1:0] cfg_count;
  logic          is_down;

  assign is_down = (mode_e'(mode) == MODE_DOWN);

  // Clamped modulus for a cfg_we write.
  assign mod_new = MW'(clamp_val(32'(mod_in), 32'd2, 32'(MAX_MOD)));

  // Preload saturates at the current modulus minus one.
  assign load_lim = CW'(clamp_val(32'(load_val), 32'd0, 32'(mod_q) - 32'd1));

  // After a reconfigure, a down counter starts at its top value.
  assign cfg_count = is_down ? CW'(mod_new - MW'(1)) : '0;

  mod_next_calc #(
    .CW (CW),
    .MW (MW)
  ) u_next (
    .count      (count_q),
    .m          (mod_q),
    .mode       (mode),
    .dir        (dir_q),
    .done       (done_q),
    .next_count (next_count),
    .next_dir   (next_dir),
    .wrap_evt   (wrap_evt),
    .tc_raw     (tc_raw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      mod_q   <= MW'(DEF_MOD);
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (cfg_we) begin
      mod_q   <= mod_new;
      count_q <= cfg_count;
      dir_q   <= !is_down;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (load) begin
      count_q <= load_lim;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
      if (is_down) begin
        dir_q <= 1'b0;
      end
    end else if (en) begin
      count_q <= next_count;
      dir_q   <= next_dir;
      wrap_q  <= wrap_evt;
      // In one-shot mode the single wrap event is the moment it finishes.
      if ((mode_e'(mode) == MODE_ONESHOT) && wrap_evt) begin
        done_q <= 1'b1;
      end
    end else begin
      wrap_q <= 1'b0;
    end
  end

  assign count = count_q;
  assign tc    = tc_raw & en;
  assign wrap  = wrap_q;
  assign dir   = dir_q;
  assign done  = done_q;

endmodule
